// File: rtl/exu_wbck_arb_if.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

// +----------------------------------------------------------------------+
// | Module  : exu_wbck_arb_if                                            |
// | Brief   : ALU/LSU writeback request channels and regfile write port  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface exu_wbck_arb_if;
  logic                    alu_wbck_i_valid;
  logic                    alu_wbck_i_ready;
  logic [`XLEN-1:0]        alu_wbck_i_wdat;
  logic [`RFIDX_WIDTH-1:0] alu_wbck_i_rdidx;

  logic                    lsu_wbck_i_valid;
  logic                    lsu_wbck_i_ready;
  logic [`XLEN-1:0]        lsu_wbck_i_wdat;
  logic [`RFIDX_WIDTH-1:0] lsu_wbck_i_rdidx;

  logic                    rf_wbck_o_valid;
  logic                    rf_wbck_o_ready;
  logic [`XLEN-1:0]        rf_wbck_o_wdat;
  logic [`RFIDX_WIDTH-1:0] rf_wbck_o_rdidx;
  logic                    rf_wbck_o_src;

  // Environment side: requesters and the regfile.
  modport master (
    output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    input  alu_wbck_i_ready,
    output lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
    input  lsu_wbck_i_ready,
    input  rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, rf_wbck_o_src,
    output rf_wbck_o_ready
  );

  // Arbiter side.
  modport slave (
    input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
    output alu_wbck_i_ready,
    input  lsu_wbck_i_valid, lsu_wbck_i_wdat, lsu_wbck_i_rdidx,
    output lsu_wbck_i_ready,
    output rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx, rf_wbck_o_src,
    input  rf_wbck_o_ready
  );
endinterface

`default_nettype wire

// File: rtl/exu_wbck_arb.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

// +----------------------------------------------------------------------+
// | Module  : exu_wbck_arb                                               |
// | Brief   : ALU/LSU writeback arbiter with a one-entry regfile buffer. |
// |           Define EXU_WBCK_STARVE_EN to add ALU anti-starvation.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module exu_wbck_arb #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  exu_wbck_arb_if.slave wbck
);

  localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

  logic                    r_buf_vld;
  logic [`XLEN-1:0]        r_buf_wdat;
  logic [`RFIDX_WIDTH-1:0] r_buf_rdidx;
  logic                    r_buf_src;

  logic                    w_accept;
  logic                    w_force_alu;
  logic                    w_grant_alu;
  logic                    w_grant_lsu;
  logic                    w_alu_hs;
  logic                    w_lsu_hs;
  logic [`XLEN-1:0]        w_sel_wdat;
  logic [`RFIDX_WIDTH-1:0] w_sel_rdidx;
  logic                    w_load;
  logic                    w_drain;
  logic [CNT_W-1:0]        w_starve_cnt;

  assign w_accept    = ~r_buf_vld | wbck.rf_wbck_o_ready;
  assign w_force_alu = (w_starve_cnt == c_STARVE_MAX);

  assign w_grant_lsu = wbck.lsu_wbck_i_valid & ~(wbck.alu_wbck_i_valid & w_force_alu);
  assign w_grant_alu = wbck.alu_wbck_i_valid & ~w_grant_lsu;

  assign wbck.alu_wbck_i_ready = w_accept & w_grant_alu;
  assign wbck.lsu_wbck_i_ready = w_accept & w_grant_lsu;

  assign w_alu_hs = wbck.alu_wbck_i_valid & wbck.alu_wbck_i_ready;
  assign w_lsu_hs = wbck.lsu_wbck_i_valid & wbck.lsu_wbck_i_ready;

  assign w_sel_wdat  = w_lsu_hs ? wbck.lsu_wbck_i_wdat  : wbck.alu_wbck_i_wdat;
  assign w_sel_rdidx = w_lsu_hs ? wbck.lsu_wbck_i_rdidx : wbck.alu_wbck_i_rdidx;

  // x0 writes complete their handshake but never occupy the buffer.
  assign w_load  = (w_alu_hs | w_lsu_hs) & (w_sel_rdidx != '0);
  assign w_drain = r_buf_vld & wbck.rf_wbck_o_ready;

`ifdef EXU_WBCK_STARVE_EN
  logic [CNT_W-1:0] r_starve_cnt;

  // Counts consecutive accepted cycles in which a waiting ALU lost to the LSU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_accept) begin
      if (wbck.alu_wbck_i_valid && w_grant_lsu) begin
        if (r_starve_cnt != c_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  assign w_starve_cnt = r_starve_cnt;
`else
  // Tied off: STARVE_MAX >= 1 keeps the force condition permanently false.
  assign w_starve_cnt = c_CNT_ONE ^ c_CNT_ONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_vld   <= 1'b0;
      r_buf_wdat  <= '0;
      r_buf_rdidx <= '0;
      r_buf_src   <= 1'b0;
    end else if (w_load) begin
      r_buf_vld   <= 1'b1;
      r_buf_wdat  <= w_sel_wdat;
      r_buf_rdidx <= w_sel_rdidx;
      r_buf_src   <= w_lsu_hs;
    end else if (w_drain) begin
      r_buf_vld   <= 1'b0;
    end
  end

  assign wbck.rf_wbck_o_valid = r_buf_vld;
  assign wbck.rf_wbck_o_wdat  = r_buf_wdat;
  assign wbck.rf_wbck_o_rdidx = r_buf_rdidx;
  assign wbck.rf_wbck_o_src   = r_buf_src;

endmodule

`default_nettype wire

// File: tb/tb_exu_wbck_arb.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

// +----------------------------------------------------------------------+
// | Module  : tb_exu_wbck_arb                                            |
// | Brief   : Directed and random bench for the writeback arbiter.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_exu_wbck_arb;

  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 4;
  localparam int XW         = `XLEN;
  localparam int RW         = `RFIDX_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  exu_wbck_arb_if wbck ();

  exu_wbck_arb #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wbck (wbck)
  );

  always #5 clk = ~clk;

  // Reference model: one pending regfile write plus a count of ALU losses.
  bit            m_vld;
  logic [XW-1:0] m_wdat;
  logic [RW-1:0] m_rdidx;
  bit            m_src;
  int            m_losses;
  bit            last_alu_hs;
  bit            last_lsu_hs;

  function automatic bit room();
    return !m_vld || wbck.rf_wbck_o_ready;
  endfunction

  function automatic bit lsu_wins();
    if (!wbck.lsu_wbck_i_valid) return 1'b0;
    if (!wbck.alu_wbck_i_valid) return 1'b1;
`ifdef EXU_WBCK_STARVE_EN
    return m_losses < STARVE_MAX;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_alu_ready();
    return room() && wbck.alu_wbck_i_valid && !lsu_wins();
  endfunction

  function automatic bit exp_lsu_ready();
    return room() && lsu_wins();
  endfunction

  function automatic bit exp_src(input int k);
`ifdef EXU_WBCK_STARVE_EN
    return (k % (STARVE_MAX + 1)) != STARVE_MAX;
`else
    return (k >= 0);
`endif
  endfunction

  task automatic model_reset();
    m_vld = 0; m_wdat = '0; m_rdidx = '0; m_src = 0; m_losses = 0;
  endtask

  task automatic tick();
    bit acc, la, ll;
    logic [RW-1:0] idx;
    logic [XW-1:0] dat;
    acc = room();
    la  = exp_alu_ready();
    ll  = exp_lsu_ready();
    @(posedge clk);
    if (acc) begin
      if (ll && wbck.alu_wbck_i_valid) m_losses = (m_losses < STARVE_MAX) ? m_losses + 1 : m_losses;
      else m_losses = 0;
    end
    idx = ll ? wbck.lsu_wbck_i_rdidx : wbck.alu_wbck_i_rdidx;
    dat = ll ? wbck.lsu_wbck_i_wdat  : wbck.alu_wbck_i_wdat;
    if ((la || ll) && idx != 0) begin
      m_vld = 1; m_wdat = dat; m_rdidx = idx; m_src = ll;
    end else if (m_vld && wbck.rf_wbck_o_ready) begin
      m_vld = 0;
    end
    last_alu_hs = la;
    last_lsu_hs = ll;
    @(negedge clk);
  endtask

  task automatic idle();
    wbck.alu_wbck_i_valid = 0; wbck.alu_wbck_i_wdat = '0; wbck.alu_wbck_i_rdidx = '0;
    wbck.lsu_wbck_i_valid = 0; wbck.lsu_wbck_i_wdat = '0; wbck.lsu_wbck_i_rdidx = '0;
    wbck.rf_wbck_o_ready  = 1;
  endtask

  task automatic drive_alu(input bit v, input logic [RW-1:0] idx, input logic [XW-1:0] dat);
    wbck.alu_wbck_i_valid = v; wbck.alu_wbck_i_rdidx = idx; wbck.alu_wbck_i_wdat = dat;
  endtask

  task automatic drive_lsu(input bit v, input logic [RW-1:0] idx, input logic [XW-1:0] dat);
    wbck.lsu_wbck_i_valid = v; wbck.lsu_wbck_i_rdidx = idx; wbck.lsu_wbck_i_wdat = dat;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    @(negedge clk); @(negedge clk);
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", wbck.rf_wbck_o_valid); end
    n_tests++; if (wbck.rf_wbck_o_wdat !== '0) begin n_fail++; $display("FAIL reset_wdat: got %h want 0", wbck.rf_wbck_o_wdat); end
    n_tests++; if (wbck.rf_wbck_o_rdidx !== '0) begin n_fail++; $display("FAIL reset_rdidx: got %0d want 0", wbck.rf_wbck_o_rdidx); end
    n_tests++; if (wbck.rf_wbck_o_src !== 1'b0) begin n_fail++; $display("FAIL reset_src: got %0b want 0", wbck.rf_wbck_o_src); end
    rst_n = 1;
    // Fill the buffer, then stall it and pull reset asynchronously.
    wbck.rf_wbck_o_ready = 0;
    drive_alu(1, RW'(1), XW'(32'h11));
    tick();
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b1) begin n_fail++; $display("FAIL reset_fill: got %0b want 1", wbck.rf_wbck_o_valid); end
    drive_alu(0, '0, '0);
    tick();
    #2 rst_n = 0;
    #1;
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_async: got %0b want 0", wbck.rf_wbck_o_valid); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    wbck.rf_wbck_o_ready = 1;
    drive_lsu(1, RW'(8), XW'(32'h88));
    #1;
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_post_idle: got %0b want 0", wbck.rf_wbck_o_valid); end
    tick();
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b1 || wbck.rf_wbck_o_rdidx !== RW'(8)) begin
      n_fail++; $display("FAIL reset_first_write: got v=%0b idx=%0d want v=1 idx=8", wbck.rf_wbck_o_valid, wbck.rf_wbck_o_rdidx); end
    idle();
    tick();
  endtask

  task automatic test_alu_single();
    drive_alu(1, RW'(5), XW'(32'hDEAD_BEEF));
    #1;
    n_tests++; if (wbck.alu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %0b want 1", wbck.alu_wbck_i_ready); end
    tick();
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b1 || wbck.rf_wbck_o_rdidx !== RW'(5) || wbck.rf_wbck_o_src !== 1'b0 || wbck.rf_wbck_o_wdat !== XW'(32'hDEAD_BEEF)) begin
      n_fail++; $display("FAIL alu_write: got v=%0b idx=%0d src=%0b dat=%h want v=1 idx=5 src=0 dat=deadbeef",
                         wbck.rf_wbck_o_valid, wbck.rf_wbck_o_rdidx, wbck.rf_wbck_o_src, wbck.rf_wbck_o_wdat); end
    // Back-to-back: one write leaves the buffer every cycle.
    for (int i = 1; i <= 4; i++) begin
      drive_alu(1, RW'(10 + i), XW'(i * 32'h1111));
      #1;
      n_tests++; if (wbck.alu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, wbck.alu_wbck_i_ready); end
      tick();
      n_tests++; if (wbck.rf_wbck_o_valid !== 1'b1 || wbck.rf_wbck_o_rdidx !== RW'(10 + i)) begin
        n_fail++; $display("FAIL b2b_write[%0d]: got v=%0b idx=%0d want v=1 idx=%0d", i, wbck.rf_wbck_o_valid, wbck.rf_wbck_o_rdidx, 10 + i); end
    end
    idle();
    tick();
  endtask

  task automatic test_priority();
    drive_alu(1, RW'(3), XW'(32'h3333));
    drive_lsu(1, RW'(7), XW'(32'h7777));
    #1;
    n_tests++; if (wbck.lsu_wbck_i_ready !== 1'b1 || wbck.alu_wbck_i_ready !== 1'b0) begin
      n_fail++; $display("FAIL prio_ready: got lsu=%0b alu=%0b want lsu=1 alu=0", wbck.lsu_wbck_i_ready, wbck.alu_wbck_i_ready); end
    tick();
    n_tests++; if (wbck.rf_wbck_o_src !== 1'b1 || wbck.rf_wbck_o_rdidx !== RW'(7)) begin
      n_fail++; $display("FAIL prio_lsu_first: got src=%0b idx=%0d want src=1 idx=7", wbck.rf_wbck_o_src, wbck.rf_wbck_o_rdidx); end
    drive_lsu(0, '0, '0);
    #1;
    n_tests++; if (wbck.alu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL prio_alu_ready: got %0b want 1", wbck.alu_wbck_i_ready); end
    tick();
    n_tests++; if (wbck.rf_wbck_o_src !== 1'b0 || wbck.rf_wbck_o_rdidx !== RW'(3) || wbck.rf_wbck_o_valid !== 1'b1) begin
      n_fail++; $display("FAIL prio_alu_second: got v=%0b src=%0b idx=%0d want v=1 src=0 idx=3", wbck.rf_wbck_o_valid, wbck.rf_wbck_o_src, wbck.rf_wbck_o_rdidx); end
    idle();
    tick();
  endtask

  task automatic test_stall();
    drive_lsu(1, RW'(9), XW'(32'hCAFE_0009));
    tick();
    drive_lsu(0, '0, '0);
    drive_alu(1, RW'(4), XW'(32'h0000_0444));
    wbck.rf_wbck_o_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (wbck.alu_wbck_i_ready !== 1'b0 || wbck.lsu_wbck_i_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got alu=%0b lsu=%0b want 0 0", i, wbck.alu_wbck_i_ready, wbck.lsu_wbck_i_ready); end
      tick();
      n_tests++; if (wbck.rf_wbck_o_valid !== 1'b1 || wbck.rf_wbck_o_rdidx !== RW'(9) || wbck.rf_wbck_o_wdat !== XW'(32'hCAFE_0009) || wbck.rf_wbck_o_src !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b idx=%0d dat=%h src=%0b want v=1 idx=9 dat=cafe0009 src=1",
                           i, wbck.rf_wbck_o_valid, wbck.rf_wbck_o_rdidx, wbck.rf_wbck_o_wdat, wbck.rf_wbck_o_src); end
    end
    wbck.rf_wbck_o_ready = 1;
    #1;
    n_tests++; if (wbck.alu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %0b want 1", wbck.alu_wbck_i_ready); end
    tick();
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b1 || wbck.rf_wbck_o_rdidx !== RW'(4) || wbck.rf_wbck_o_src !== 1'b0) begin
      n_fail++; $display("FAIL stall_refill: got v=%0b idx=%0d src=%0b want v=1 idx=4 src=0", wbck.rf_wbck_o_valid, wbck.rf_wbck_o_rdidx, wbck.rf_wbck_o_src); end
    idle();
    tick();
  endtask

  task automatic contend(input string name, input int cycles);
    drive_alu(1, RW'(2), XW'(32'hA1A1));
    drive_lsu(1, RW'(6), XW'(32'hB2B2));
    for (int k = 0; k < cycles; k++) begin
      #1;
      n_tests++; if (wbck.lsu_wbck_i_ready !== exp_src(k) || wbck.alu_wbck_i_ready !== !exp_src(k)) begin
        n_fail++; $display("FAIL %s_ready[%0d]: got lsu=%0b alu=%0b want lsu=%0b alu=%0b", name, k,
                           wbck.lsu_wbck_i_ready, wbck.alu_wbck_i_ready, exp_src(k), !exp_src(k)); end
      tick();
      n_tests++; if (wbck.rf_wbck_o_src !== exp_src(k) || wbck.rf_wbck_o_valid !== 1'b1) begin
        n_fail++; $display("FAIL %s_src[%0d]: got v=%0b src=%0b want v=1 src=%0b", name, k, wbck.rf_wbck_o_valid, wbck.rf_wbck_o_src, exp_src(k)); end
    end
  endtask

  task automatic test_starvation();
    contend("starve", 3 * (STARVE_MAX + 1));
    idle();
    tick();
  endtask

  task automatic test_rdidx_zero();
    contend("pre_zero", 2);
    drive_lsu(0, '0, '0);
    drive_alu(1, '0, XW'(32'h0BAD));
    #1;
    n_tests++; if (wbck.alu_wbck_i_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %0b want 1", wbck.alu_wbck_i_ready); end
    tick();
    n_tests++; if (wbck.rf_wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL zero_no_write: got %0b want 0", wbck.rf_wbck_o_valid); end
    // A cleared counter restarts the full LSU run before the ALU is forced.
    contend("post_zero", STARVE_MAX + 1);
    idle();
    tick();
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      if (!wbck.alu_wbck_i_valid || last_alu_hs) begin
        logic [RW-1:0] ri;
        ri = RW'($urandom);
        if ($urandom_range(0, 7) == 0) ri = '0;
        drive_alu($urandom_range(0, 3) != 0, ri, XW'($urandom));
      end
      if (!wbck.lsu_wbck_i_valid || last_lsu_hs) begin
        logic [RW-1:0] rl;
        rl = RW'($urandom);
        if ($urandom_range(0, 7) == 0) rl = '0;
        drive_lsu($urandom_range(0, 2) != 0, rl, XW'($urandom));
      end
      wbck.rf_wbck_o_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++; if (wbck.alu_wbck_i_ready !== exp_alu_ready() || wbck.lsu_wbck_i_ready !== exp_lsu_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got alu=%0b lsu=%0b want alu=%0b lsu=%0b", c,
                           wbck.alu_wbck_i_ready, wbck.lsu_wbck_i_ready, exp_alu_ready(), exp_lsu_ready()); end
      tick();
      n_tests++; if (wbck.rf_wbck_o_valid !== m_vld || wbck.rf_wbck_o_rdidx !== m_rdidx || wbck.rf_wbck_o_wdat !== m_wdat || wbck.rf_wbck_o_src !== m_src) begin
        n_fail++; $display("FAIL rand_out[%0d]: got v=%0b idx=%0d dat=%h src=%0b want v=%0b idx=%0d dat=%h src=%0b", c,
                           wbck.rf_wbck_o_valid, wbck.rf_wbck_o_rdidx, wbck.rf_wbck_o_wdat, wbck.rf_wbck_o_src,
                           m_vld, m_rdidx, m_wdat, m_src); end
    end
    idle();
    tick();
  endtask

  initial begin
    last_alu_hs = 0;
    last_lsu_hs = 0;
    test_reset();
    test_alu_single();
    test_priority();
    test_stall();
    test_starvation();
    test_rdidx_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
